// File: rtl/mac_col_kbank.sv
// One column of the systolic attention array: captures a bank of keys during a skewed
// load phase, forwards queries/instructions, and accumulates saturating dot products.
module mac_col_kbank #(
  parameter int bw = 8,
  parameter int bw_psum = 2*bw+6,
  parameter int pr = 8,
  parameter int n_key = 4,
  parameter int col_id = 0,
  localparam int ksw = (n_key > 1) ? $clog2(n_key) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         i_inst,
  input  logic [ksw-1:0]     i_ksel,
  input  logic [pr*bw-1:0]   q_in,
  output logic [pr*bw-1:0]   q_out,
  output logic [2:0]         o_inst,
  output logic [ksw-1:0]     o_ksel,
  output logic [bw_psum-1:0] out,
  output logic               fifo_wr,
  output logic               o_sat,
  output logic               load_done
);

  localparam int key_lo = col_id*n_key;
  localparam int key_hi = (col_id+1)*n_key;
  localparam int cw = $clog2(key_hi+1);
  localparam int pw = 2*bw + $clog2(pr);

  logic [2:0]         inst_q, inst_2q, inst_3q, inst_4q;
  logic [pr*bw-1:0]   query_q, qout_q;
  logic [pr*bw-1:0]   key_q [n_key];
  logic [ksw-1:0]     ksel_q, oksel_q;
  logic [bw_psum-1:0] prod_q, acc_q;
  logic               fresh_q, sat_q, load_done_q;
  logic [cw-1:0]      cnt_q;

  logic               load_start, exec_1, exec_2, exec_3, in_range, last_slot, ksel_ok;
  logic [cw-1:0]      cnt_eff, slot;
  logic [pr*bw-1:0]   sel_key;
  logic signed [2*bw-1:0] lane_prod [pr];
  logic signed [pw-1:0]   dot;
  logic [bw_psum:0]   acc_sum;
  logic               acc_ovf;
  logic [bw_psum-1:0] acc_next;

  assign load_start = inst_q[0] & ~inst_2q[0];
  assign exec_1     = inst_q[1] & ~inst_q[0];
  assign exec_2     = inst_2q[1] & ~inst_2q[0];
  assign exec_3     = inst_3q[1] & ~inst_3q[0];
  assign cnt_eff    = load_start ? '0 : cnt_q;
  // Below-window counts wrap to values above n_key, so one compare covers both bounds.
  assign slot       = cnt_eff - cw'(key_lo);
  assign in_range   = slot < cw'(n_key);
  assign last_slot  = in_range && (slot == cw'(n_key-1));
  assign ksel_ok    = {1'b0, i_ksel} < (ksw+1)'(n_key);

  always_comb begin
    sel_key = key_q[0];
    for (int s = 0; s < n_key; s++)
      if (ksel_q == ksw'(s)) sel_key = key_q[s];
  end

  for (genvar k = 0; k < pr; k++) begin : g_lane
    assign lane_prod[k] = (2*bw)'($signed(query_q[k*bw +: bw])) *
                          (2*bw)'($signed(sel_key[k*bw +: bw]));
  end

  always_comb begin
    dot = '0;
    for (int k = 0; k < pr; k++) dot = dot + pw'(lane_prod[k]);
  end

  // One guard bit catches overflow; clamp toward the sign of the true sum.
  always_comb begin
    acc_sum = fresh_q ? {prod_q[bw_psum-1], prod_q}
                      : {acc_q[bw_psum-1], acc_q} + {prod_q[bw_psum-1], prod_q};
    acc_ovf = acc_sum[bw_psum] ^ acc_sum[bw_psum-1];
    if (!acc_ovf)             acc_next = acc_sum[bw_psum-1:0];
    else if (acc_sum[bw_psum]) acc_next = {1'b1, {(bw_psum-1){1'b0}}};
    else                      acc_next = {1'b0, {(bw_psum-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q      <= '0;
      inst_2q     <= '0;
      inst_3q     <= '0;
      inst_4q     <= '0;
      qout_q      <= '0;
      oksel_q     <= '0;
      query_q     <= '0;
      ksel_q      <= '0;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
      for (int s = 0; s < n_key; s++) key_q[s] <= '0;
    end else begin
      inst_q  <= i_inst;
      inst_2q <= inst_q;
      inst_3q <= inst_2q;
      inst_4q <= inst_3q;
      qout_q  <= q_in;
      oksel_q <= i_ksel;
      if (inst_q[0]) begin
        query_q <= q_in;
        for (int s = 0; s < n_key; s++)
          if (in_range && slot == cw'(s)) key_q[s] <= q_in;
        cnt_q <= (cnt_eff == cw'(key_hi)) ? cnt_eff : cnt_eff + cw'(1);
        if (last_slot)       load_done_q <= 1'b1;
        else if (load_start) load_done_q <= 1'b0;
      end else if (exec_1) begin
        query_q <= q_in;
        ksel_q  <= ksel_ok ? i_ksel : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q  <= '0;
      acc_q   <= '0;
      fresh_q <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      if (exec_2) prod_q <= bw_psum'(dot);
      if (exec_3) begin
        acc_q   <= acc_next;
        sat_q   <= acc_ovf | (sat_q & ~fresh_q);
        fresh_q <= ~inst_3q[2];
      end
    end
  end

  assign q_out     = qout_q;
  assign o_inst    = inst_q;
  assign o_ksel    = oksel_q;
  assign out       = acc_q;
  assign fifo_wr   = inst_4q[1] & ~inst_4q[0] & ~inst_4q[2];
  assign o_sat     = sat_q & fifo_wr;
  assign load_done = load_done_q;

endmodule
